// File: rtl/snake_pkg.sv
// snake_pkg: shared geometry defaults and scan FSM states for the snake line renderer
package snake_pkg;
    localparam int CELL     = 10;
    localparam int GRID_W   = 64;
    localparam int GRID_H   = 48;
    localparam int MAX_LEN  = 128;
    localparam int N_APPLES = 2;
    localparam int COL_W    = 6;
    localparam int ROW_W    = 6;
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ADDR, S_CHECK, S_COMMIT} scan_state_t;
endpackage

// File: rtl/snake_cell_counter.sv
// snake_cell_counter: cell index plus sub-cell counter advanced by a strobe, saturating at LAST
module snake_cell_counter #(
    parameter int CELL = snake_pkg::CELL,
    parameter int W    = snake_pkg::COL_W,
    parameter int LAST = snake_pkg::GRID_W - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] idx
);
    localparam int SW = $clog2(CELL);
    logic [SW-1:0] sub;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub <= '0;
            idx <= '0;
        end else if (clr) begin
            sub <= '0;
            idx <= '0;
        end else if (inc) begin
            sub <= sub == SW'(CELL - 1) ? '0 : sub + 1'b1;
            if (sub == SW'(CELL - 1) && idx != W'(LAST))
                idx <= idx + 1'b1;
        end
    end
endmodule

// File: rtl/snake_line_renderer.sv
// snake_line_renderer: per-line body bitmap built from a segment RAM walk, plus registered pixel masks.
// Define SNAKE_SELF_HIT_EN to add the self_hit head-versus-body collision pulse.
module snake_line_renderer #(
    parameter int CELL     = snake_pkg::CELL,
    parameter int GRID_W   = snake_pkg::GRID_W,
    parameter int GRID_H   = snake_pkg::GRID_H,
    parameter int MAX_LEN  = snake_pkg::MAX_LEN,
    parameter int N_APPLES = snake_pkg::N_APPLES,
    parameter int COL_W    = snake_pkg::COL_W,
    parameter int ROW_W    = snake_pkg::ROW_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pix_ce,
    input  logic                        disp,
    input  logic                        frame_start,
    input  logic                        line_start,
    input  logic [COL_W-1:0]            head_col,
    input  logic [ROW_W-1:0]            head_row,
    input  logic [N_APPLES*COL_W-1:0]   apple_col_bus,
    input  logic [N_APPLES*ROW_W-1:0]   apple_row_bus,
    input  logic [N_APPLES-1:0]         apple_valid,
    input  logic [7:0]                  snake_len,
    output logic [$clog2(MAX_LEN)-1:0]  seg_addr,
    input  logic [COL_W-1:0]            seg_col,
    input  logic [ROW_W-1:0]            seg_row,
    output logic                        head_px,
    output logic                        body_px,
    output logic                        apple_px,
    output logic                        border_px,
    output logic                        scan_busy,
    output logic                        scan_overrun
`ifdef SNAKE_SELF_HIT_EN
    ,
    output logic                        self_hit
`endif
);
    import snake_pkg::*;
    localparam int AW = $clog2(MAX_LEN);
    scan_state_t state, nxt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row, tgt;
    logic [7:0] len, idx;
    logic [GRID_W-1:0] shadow, active;
    logic disp_q, busy, abort, apple_hit;

    snake_cell_counter #(.CELL(CELL), .W(COL_W), .LAST(GRID_W - 1)) u_col (
        .clk(clk), .rst(rst), .clr(!disp), .inc(pix_ce && disp), .idx(col)
    );
    snake_cell_counter #(.CELL(CELL), .W(ROW_W), .LAST(GRID_H - 1)) u_row (
        .clk(clk), .rst(rst), .clr(line_start && frame_start), .inc(line_start), .idx(row)
    );

    assign busy      = state != S_IDLE;
    assign scan_busy = busy;
    assign seg_addr  = idx[AW-1:0];
    assign abort     = disp && !disp_q && busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (line_start)
            nxt = S_CLEAR;
        else if (abort)
            nxt = S_IDLE;
        else
            case (state)
                S_CLEAR:  nxt = len <= 8'd1 ? S_COMMIT : S_ADDR;
                S_ADDR:   nxt = S_CHECK;
                S_CHECK:  nxt = idx == len ? S_COMMIT : S_CHECK;
                S_COMMIT: nxt = S_IDLE;
                default:  nxt = state;
            endcase
    end

    // idx runs one ahead of the RAM data, so CHECK tests segment idx-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q       <= 1'b0;
            len          <= '0;
            idx          <= '0;
            tgt          <= '0;
            shadow       <= '0;
            active       <= '0;
            scan_overrun <= 1'b0;
        end else begin
            disp_q <= disp;
            if (line_start) begin
                len <= snake_len;
                if (busy)
                    scan_overrun <= 1'b1;
            end else if (abort) begin
                scan_overrun <= 1'b1;
                active       <= '0;
            end else
                case (state)
                    S_CLEAR: begin
                        shadow <= '0;
                        idx    <= 8'd1;
                        tgt    <= row;
                    end
                    S_ADDR, S_CHECK: begin
                        idx <= idx + 1'b1;
                        if (state == S_CHECK && seg_row == tgt)
                            shadow[seg_col] <= 1'b1;
                    end
                    S_COMMIT: active <= shadow;
                    default: ;
                endcase
        end
    end

    always_comb begin
        apple_hit = 1'b0;
        for (int i = 0; i < N_APPLES; i++)
            apple_hit = apple_hit | (apple_valid[i] && apple_col_bus[i*COL_W +: COL_W] == col
                                     && apple_row_bus[i*ROW_W +: ROW_W] == row);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || !disp) begin
            head_px   <= 1'b0;
            body_px   <= 1'b0;
            apple_px  <= 1'b0;
            border_px <= 1'b0;
        end else if (pix_ce) begin
            head_px   <= col == head_col && row == head_row;
            body_px   <= active[col] && !abort;
            apple_px  <= apple_hit;
            border_px <= col == '0 || col == COL_W'(GRID_W - 1) || row == '0 || row == ROW_W'(GRID_H - 1);
        end
    end

`ifdef SNAKE_SELF_HIT_EN
    logic hit;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit      <= 1'b0;
            self_hit <= 1'b0;
        end else begin
            self_hit <= frame_start && hit;
            hit      <= frame_start ? 1'b0 : hit | (state == S_CHECK && seg_col == head_col && seg_row == head_row);
        end
    end
`endif
endmodule
